// File: rtl/ysyx_23060203_ifu.sv
// Instruction fetch unit: one outstanding 32-bit read, valid/ready toward decode, redirect from execute.
// Optional misaligned-fetch trapping is enabled by defining YSYX_23060203_IFU_MISALIGN_EN.
module ysyx_23060203_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    input  logic        mem_resp_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        out_err,
    output logic        out_misalign,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic [31:0] inst_q, inst_d;
    logic        err_q, err_d;
    logic        mis_q, mis_d;
    logic        misaligned;

`ifdef YSYX_23060203_IFU_MISALIGN_EN
    assign misaligned = (pc_q[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            kill_q  <= 1'b0;
            inst_q  <= 32'd0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
            inst_q  <= inst_d;
            err_q   <= err_d;
            mis_q   <= mis_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        kill_d        = kill_q;
        inst_d        = inst_q;
        err_d         = err_q;
        mis_d         = mis_q;
        mem_req_valid = 1'b0;
        out_valid     = 1'b0;
        unique case (state_q)
            IDLE: begin
                state_d = REQ;
                if (redirect_valid) pc_d = redirect_pc;
            end
            REQ: begin
                if (misaligned) begin
                    // No bus traffic; a NOP stands in for the faulting word.
                    if (redirect_valid) begin
                        pc_d = redirect_pc;
                    end else begin
                        state_d = HOLD;
                        mis_d   = 1'b1;
                        inst_d  = 32'h0000_0013;
                        err_d   = 1'b0;
                    end
                end else begin
                    mem_req_valid = 1'b1;
                    if (redirect_valid) begin
                        pc_d = redirect_pc;
                        if (mem_req_ready) begin
                            state_d = WAIT;
                            kill_d  = 1'b1;
                        end
                    end else if (mem_req_ready) begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                    if (mem_resp_valid) begin
                        kill_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        kill_d = 1'b1;
                    end
                end else if (mem_resp_valid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        inst_d  = mem_resp_data;
                        err_d   = mem_resp_err;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                out_valid = ~redirect_valid;
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    mis_d   = 1'b0;
                    state_d = REQ;
                end else if (out_ready) begin
                    pc_d    = pc_q + 32'd4;
                    mis_d   = 1'b0;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_req_addr = pc_q;
    assign out_inst     = inst_q;
    assign out_pc       = pc_q;
    assign out_err      = err_q;
`ifdef YSYX_23060203_IFU_MISALIGN_EN
    assign out_misalign = mis_q;
`else
    assign out_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_23060203_ifu.sv
// Directed bench for ysyx_23060203_ifu; memory handshakes are driven cycle by cycle by hand.
module tb_ysyx_23060203_ifu;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid, mem_resp_err;
    logic [31:0] mem_resp_data;
    logic        out_valid, out_ready, out_err, out_misalign;
    logic [31:0] out_inst, out_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int errors = 0;
    int checks = 0;
    int xfers  = 0;

    always #5 clk = ~clk;

    ysyx_23060203_ifu dut (
        .clk(clk), .rst(rst),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_err(mem_resp_err),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
        .out_err(out_err), .out_misalign(out_misalign),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always @(posedge clk) if (!rst && out_valid && out_ready) xfers <= xfers + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 32'd0;
        mem_resp_err = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
        tick(); tick();
        chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_addr", mem_req_addr, 32'h8000_0000);
        chk("rst_inst", out_inst, 32'd0);
        chk("rst_err", {31'd0, out_err}, 32'd0);
        chk("rst_mis", {31'd0, out_misalign}, 32'd0);

        // first fetch
        rst = 1'b0;
        tick();
        chk("first_req_valid", {31'd0, mem_req_valid}, 32'd1);
        chk("first_req_addr", mem_req_addr, 32'h8000_0000);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0413;
        #1;
        chk("wait_no_req", {31'd0, mem_req_valid}, 32'd0);
        chk("wait_no_out", {31'd0, out_valid}, 32'd0);
        tick();
        mem_resp_valid = 1'b0;
        #1;
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_pc", out_pc, 32'h8000_0000);
        chk("hold_inst", out_inst, 32'h0000_0413);

        // backpressure: five stalled cycles then one transfer
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_inst", out_inst, 32'h0000_0413);
            chk("bp_pc", out_pc, 32'h8000_0000);
            chk("bp_no_req", {31'd0, mem_req_valid}, 32'd0);
            tick();
        end
        chk("bp_xfers0", xfers, 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        chk("bp_xfers1", xfers, 32'd1);
        chk("next_req_valid", {31'd0, mem_req_valid}, 32'd1);
        chk("next_req_addr", mem_req_addr, 32'h8000_0004);
        chk("next_out_valid", {31'd0, out_valid}, 32'd0);

        // redirect in WAIT, response two cycles later is dropped
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("kill_addr", mem_req_addr, 32'h8000_0100);
        chk("kill_no_req", {31'd0, mem_req_valid}, 32'd0);
        tick();
        mem_resp_valid = 1'b1; mem_resp_data = 32'hDEAD_BEEF;
        tick();
        mem_resp_valid = 1'b0;
        #1;
        chk("kill_dropped", {31'd0, out_valid}, 32'd0);
        chk("kill_req_valid", {31'd0, mem_req_valid}, 32'd1);
        chk("kill_req_addr", mem_req_addr, 32'h8000_0100);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h0010_0093;
        tick();
        mem_resp_valid = 1'b0;
        #1;
        chk("rd_valid", {31'd0, out_valid}, 32'd1);
        chk("rd_inst", out_inst, 32'h0010_0093);
        chk("rd_pc", out_pc, 32'h8000_0100);

        // redirect in HOLD with out_ready high: no transfer
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0200; out_ready = 1'b1;
        #1;
        chk("hold_rd_masked", {31'd0, out_valid}, 32'd0);
        tick();
        redirect_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("hold_rd_xfers", xfers, 32'd1);
        chk("hold_rd_req", {31'd0, mem_req_valid}, 32'd1);
        chk("hold_rd_addr", mem_req_addr, 32'h8000_0200);

        // redirect in REQ while stalled, then access fault
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0008;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("req_rd_addr", mem_req_addr, 32'h8000_0008);
        chk("req_rd_valid", {31'd0, mem_req_valid}, 32'd1);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_err = 1'b1; mem_resp_data = 32'd0;
        tick();
        mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
        #1;
        chk("err_valid", {31'd0, out_valid}, 32'd1);
        chk("err_flag", {31'd0, out_err}, 32'd1);
        chk("err_pc", out_pc, 32'h8000_0008);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        chk("err_next_addr", mem_req_addr, 32'h8000_000C);
        tick();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0013;
        tick();
        mem_resp_valid = 1'b0;
        #1;
        chk("noerr_flag", {31'd0, out_err}, 32'd0);
        chk("noerr_pc", out_pc, 32'h8000_000C);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        chk("xfers3", xfers, 32'd3);

        // redirect in REQ with ready high: old request issued then killed
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; mem_req_ready = 1'b1;
        tick();
        redirect_valid = 1'b0; mem_req_ready = 1'b0;
        #1;
        chk("reqrdy_addr", mem_req_addr, 32'hFFFF_FFFC);
        chk("reqrdy_wait", {31'd0, mem_req_valid}, 32'd0);
        mem_resp_valid = 1'b1; mem_resp_data = 32'h1111_1111;
        tick();
        mem_resp_valid = 1'b0;
        #1;
        chk("reqrdy_drop", {31'd0, out_valid}, 32'd0);
        chk("reqrdy_reissue", {31'd0, mem_req_valid}, 32'd1);

        // PC wrap from 0xFFFFFFFC to 0
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h2222_2222;
        tick();
        mem_resp_valid = 1'b0;
        #1;
        chk("wrap_inst", out_inst, 32'h2222_2222);
        chk("wrap_pc", out_pc, 32'hFFFF_FFFC);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        chk("wrap_addr", mem_req_addr, 32'h0000_0000);

        // redirect in WAIT coinciding with the response
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h3333_3333;
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0300;
        tick();
        mem_resp_valid = 1'b0; redirect_valid = 1'b0;
        #1;
        chk("same_drop", {31'd0, out_valid}, 32'd0);
        chk("same_addr", mem_req_addr, 32'h8000_0300);
        chk("same_req", {31'd0, mem_req_valid}, 32'd1);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h4444_4444;
        tick();
        mem_resp_valid = 1'b0;
        #1;
        chk("same_next_inst", out_inst, 32'h4444_4444);
        chk("same_next_pc", out_pc, 32'h8000_0300);

        // reset while holding an instruction
        rst = 1'b1;
        tick();
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_addr", mem_req_addr, 32'h8000_0000);
        chk("midrst_inst", out_inst, 32'd0);
        rst = 1'b0;
        tick();

        // misaligned target
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
        tick();
        redirect_valid = 1'b0;
        #1;
`ifdef YSYX_23060203_IFU_MISALIGN_EN
        chk("mis_no_req", {31'd0, mem_req_valid}, 32'd0);
        tick();
        chk("mis_valid", {31'd0, out_valid}, 32'd1);
        chk("mis_flag", {31'd0, out_misalign}, 32'd1);
        chk("mis_pc", out_pc, 32'h8000_0102);
        chk("mis_inst", out_inst, 32'h0000_0013);
        chk("mis_err", {31'd0, out_err}, 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        chk("mis_clear", {31'd0, out_misalign}, 32'd0);
`else
        chk("mis_req", {31'd0, mem_req_valid}, 32'd1);
        chk("mis_addr", mem_req_addr, 32'h8000_0102);
        chk("mis_flag0", {31'd0, out_misalign}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_23060203_ifu.md
# ysyx_23060203_ifu

Instruction fetch unit for the ysyx_23060203 NPC core. It holds the fetch PC, issues one 32-bit instruction read at a time over a simple request/response memory port, and presents `inst`/`pc` to the decode stage through a valid/ready handshake. A redirect port from execute (jumps, branches, traps, `mret`) retargets the PC and kills any wrong-path fetch in flight.

## Interface
Parameters:
- `RESET_PC`, default `32'h8000_0000`: first fetch address after reset.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `mem_req_valid`  out  1  fetch request valid.
- `mem_req_ready`  in  1  memory accepts the request when high together with valid.
- `mem_req_addr`  out  32  fetch address; always equal to the PC register.
- `mem_resp_valid`  in  1  response valid; never in the same cycle as acceptance.
- `mem_resp_data`  in  32  instruction word.
- `mem_resp_err`  in  1  access fault for this response.
- `out_valid`  out  1  instruction valid toward decode.
- `out_ready`  in  1  decode accepts.
- `out_inst`  out  32  instruction word.
- `out_pc`  out  32  address of `out_inst`.
- `out_err`  out  1  access fault flag travelling with the instruction.
- `out_misalign`  out  1  misaligned fetch flag; see Configuration.
- `redirect_valid`  in  1  execute requests a PC change.
- `redirect_pc`  in  32  new fetch address.

## Operation
- Registers: `state`, `pc[31:0]`, `kill`, `inst_q[31:0]`, `err_q`, `mis_q`.
- States and transitions:
  - IDLE: reset state. Moves to REQ unconditionally.
  - REQ: `mem_req_valid=1`. On `mem_req_ready`, moves to WAIT.
  - WAIT: waits for `mem_resp_valid`.
    - With `kill=0`: latches `inst_q<=mem_resp_data` and `err_q<=mem_resp_err`, then moves to HOLD.
    - With `kill=1`: drops the data, clears `kill`, and moves to REQ.
  - HOLD: `out_valid=~redirect_valid`. On `out_valid&out_ready`, sets `pc<=pc+32'd4` (mod 2^32; wraps from `0xFFFFFFFC` to `0`) and moves to REQ.
- Redirect handling (redirect has priority over every other event):
  - REQ, `mem_req_ready=0`: `pc<=redirect_pc`; stays in REQ. The address may change while valid is held, because memory samples only on `valid&ready`.
  - REQ, `mem_req_ready=1`: the old-PC request is issued; moves to WAIT with `kill<=1` and `pc<=redirect_pc`.
  - WAIT, no response: `kill<=1`, `pc<=redirect_pc`.
  - WAIT, response in the same cycle: the response is dropped, `pc<=redirect_pc`, `kill<=0`, and the block moves to REQ.
  - HOLD: the held instruction is discarded, `pc<=redirect_pc`, and the block moves to REQ. `out_valid` is masked low in that cycle, so no transfer occurs.
  - IDLE: `pc<=redirect_pc`.
- `out_inst=inst_q`, `out_pc=pc`, `out_err=err_q`, `out_misalign=mis_q`. These values are meaningful only while `out_valid` is high.
- At most one outstanding memory request.

## Timing
- Reset values while `rst` is high: state IDLE, `pc=RESET_PC`, `kill=0`, `inst_q=0`, `err_q=0`, `mis_q=0`. As a result, `mem_req_valid=0`, `out_valid=0`, `mem_req_addr=RESET_PC`, and `out_inst`, `out_err`, `out_misalign` are all 0.
- First `mem_req_valid` occurs 1 cycle after `rst` deasserts (IDLE→REQ).
- Minimum throughput is 3 cycles per instruction (REQ, WAIT, HOLD), given ready=1 and a response 1 cycle after acceptance.
- `out_valid` rises the cycle after `mem_resp_valid`.
- The outputs are stable while `out_valid=1&out_ready=0`.
- Reset asserted mid-fetch:
  - The block returns to IDLE with reset values.
  - A late response arriving in IDLE or REQ is ignored.
  - The memory must be reset with the core.

## Configuration
- `YSYX_23060203_IFU_MISALIGN_EN` defined:
  - In REQ, if `pc[1:0]!=0`, no memory request is issued (`mem_req_valid=0`).
  - The block moves directly to HOLD with `mis_q<=1`, `inst_q<=32'h0000_0013`, `err_q<=0`.
  - `mis_q` clears when the block leaves HOLD.
- Undefined: `out_misalign` is tied to 0, and `pc[1:0]` is issued to memory unchanged.

## Test plan
- Reset, memory with ready=1 and 1-cycle response returning `0x00000413` at `0x80000000`:
  - First request at `0x80000000`, 1 cycle after reset release.
  - `out_valid` with `out_pc=0x80000000`, `out_inst=0x00000413`.
  - Next request at `0x80000004`.
- Backpressure: `out_ready=0` for 5 cycles, then 1 → outputs are held constant, no new `mem_req_valid` appears, and exactly one transfer occurs.
- Redirect to `0x80000100` in the WAIT cycle; response `0xDEADBEEF` arrives 2 cycles later:
  - The response is dropped and never reaches `out_valid`.
  - The next request goes to `0x80000100`.
- Redirect in HOLD with `out_ready=1` in the same cycle to `0x80000200`:
  - No transfer occurs (`out_valid=0` that cycle).
  - The next request goes to `0x80000200`.
- `mem_resp_err=1` at `0x80000008` → `out_err=1` with `out_pc=0x80000008`; the following fetch has `out_err=0`.
- With the macro defined, redirect to `0x80000102` → no memory request; `out_valid` with `out_misalign=1`, `out_pc=0x80000102`, `out_inst=0x00000013`.
